// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package counter_pkg;

    localparam int unsigned CTR_W = 4;
    localparam int unsigned REP_W = 4;

    // Encoding of the counter's up_down pin
    localparam logic CTR_UP   = 1'b0;
    localparam logic CTR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } sweep_state_t;

    typedef struct packed {
        logic [CTR_W-1:0] start_val;
        logic [CTR_W-1:0] end_val;
        logic [REP_W-1:0] reps;
        logic             pingpong;
    } sweep_cmd_t;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Sweep command valid/ready channel between host and sequencer.
interface counter_sweep_ctrl_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned RW = 4
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_start;
    logic [W-1:0]  cmd_end;
    logic [RW-1:0] cmd_reps;
    logic          cmd_pingpong;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_end,
        output cmd_reps,
        output cmd_pingpong,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_end,
        input  cmd_reps,
        input  cmd_pingpong,
        output cmd_ready
    );

endinterface

// File: rtl/up_down_counter.sv
// Loadable up/down counter driven by the sweep sequencer; load wins over enable.
module up_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         up_down,
    input  logic         load,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: load, step up/down, or hold
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = data_in;
        end else if (enable) begin
            count_d = up_down ? count_q - W'(1) : count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for up_down_counter: takes start/end/repeat commands and drives the
// counter pins until the programmed sequence completes.
// Optional feature: define COUNTER_SWEEP_PINGPONG_EN to enable ping-pong repeats; when
// undefined, cmd_pingpong is ignored and every repeat reloads the start value.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned RW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_sweep_ctrl_if.slave   cmd,
    input  logic                  abort,
    input  logic [W-1:0]          ctr_count,
    output logic                  ctr_enable,
    output logic                  ctr_up_down,
    output logic                  ctr_load,
    output logic [W-1:0]          ctr_data_in,
    output logic                  busy,
    output logic                  done
);

    sweep_state_t  state_q, state_d;
    logic [W-1:0]  start_q, start_d;
    logic [W-1:0]  end_q, end_d;
    logic [RW-1:0] reps_q, reps_d;
    logic          dir_q, dir_d;

`ifdef COUNTER_SWEEP_PINGPONG_EN
    logic          pp_q, pp_d;
`else
    logic          unused_pingpong;
    assign unused_pingpong = cmd.cmd_pingpong;
`endif

    // Next-state, command latching and counter pin decode
    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        end_d         = end_q;
        reps_d        = reps_q;
        dir_d         = dir_q;
`ifdef COUNTER_SWEEP_PINGPONG_EN
        pp_d          = pp_q;
`endif
        cmd.cmd_ready = 1'b0;
        ctr_enable    = 1'b0;
        ctr_up_down   = 1'b0;
        ctr_load      = 1'b0;
        ctr_data_in   = '0;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd.cmd_ready = 1'b1;
                // abort is deliberately ignored here
                if (cmd.cmd_valid) begin
                    start_d = cmd.cmd_start;
                    end_d   = cmd.cmd_end;
                    reps_d  = cmd.cmd_reps;
                    dir_d   = (cmd.cmd_end < cmd.cmd_start) ? CTR_DOWN : CTR_UP;
`ifdef COUNTER_SWEEP_PINGPONG_EN
                    pp_d    = cmd.cmd_pingpong;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ctr_up_down = dir_q;
                ctr_data_in = start_q;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    ctr_load = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                ctr_up_down = dir_q;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Combinational so the counter stops exactly on the end value
                    ctr_enable = (ctr_count != end_q);
                    if (ctr_count == end_q) begin
                        if (reps_q == '0) begin
                            state_d = StDone;
                        end else begin
                            reps_d = reps_q - RW'(1);
`ifdef COUNTER_SWEEP_PINGPONG_EN
                            if (pp_q) begin
                                // Bounce back from the far endpoint without reloading
                                start_d = end_q;
                                end_d   = start_q;
                                dir_d   = ~dir_q;
                            end else begin
                                state_d = StLoad;
                            end
`else
                            state_d = StLoad;
`endif
                        end
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            start_q <= '0;
            end_q   <= '0;
            reps_q  <= '0;
            dir_q   <= CTR_UP;
`ifdef COUNTER_SWEEP_PINGPONG_EN
            pp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            reps_q  <= reps_d;
            dir_q   <= dir_d;
`ifdef COUNTER_SWEEP_PINGPONG_EN
            pp_q    <= pp_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl paired with up_down_counter.
module tb_counter_sweep_ctrl;
    import counter_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned RW = 4;

    logic         clk;
    logic         rst;
    logic         abort;
    logic [W-1:0] ctr_count;
    logic         ctr_enable;
    logic         ctr_up_down;
    logic         ctr_load;
    logic [W-1:0] ctr_data_in;
    logic         busy;
    logic         done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    counter_sweep_ctrl_if #(.W(W), .RW(RW)) cmd_if ();

    counter_sweep_ctrl #(.W(W), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if.slave),
        .abort       (abort),
        .ctr_count   (ctr_count),
        .ctr_enable  (ctr_enable),
        .ctr_up_down (ctr_up_down),
        .ctr_load    (ctr_load),
        .ctr_data_in (ctr_data_in),
        .busy        (busy),
        .done        (done)
    );

    up_down_counter #(.W(W)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .enable  (ctr_enable),
        .up_down (ctr_up_down),
        .load    (ctr_load),
        .data_in (ctr_data_in),
        .count   (ctr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command; returns just after the handshake edge (cycle T ends there)
    task automatic send_cmd(input sweep_cmd_t c, input logic with_abort);
        @(negedge clk);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_start    = c.start_val;
        cmd_if.cmd_end      = c.end_val;
        cmd_if.cmd_reps     = c.reps;
        cmd_if.cmd_pingpong = c.pingpong;
        abort               = with_abort;
        check("ready_at_T", {63'd0, cmd_if.cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        abort            = 1'b0;
    endtask

    // Observe a sweep cycle by cycle (k = cycles after T); bounded by a cycle budget
    task automatic run_sweep(input logic [W-1:0] start, output logic [63:0] trace,
                             output int done_cyc, output int done_cnt, output bit en_seen,
                             output bit overlap, output bit dir_at2, output bit ready_ok);
        logic [W-1:0] prev;
        trace    = '0;
        done_cyc = -1;
        done_cnt = 0;
        en_seen  = 1'b0;
        overlap  = 1'b0;
        dir_at2  = 1'b0;
        ready_ok = 1'b1;
        prev     = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("load_at_T1", {63'd0, ctr_load}, 64'd1);
                check("data_in_at_T1", {60'd0, ctr_data_in}, {60'd0, start});
            end
            if (k == 2) begin
                trace   = {60'd0, ctr_count};
                prev    = ctr_count;
                dir_at2 = ctr_up_down;
            end else if (k > 2 && ctr_count != prev) begin
                trace = {trace[59:0], ctr_count};
                prev  = ctr_count;
            end
            if (ctr_enable) en_seen = 1'b1;
            if (ctr_enable && ctr_load) overlap = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc < 0 && cmd_if.cmd_ready) ready_ok = 1'b0;
            if (done_cyc >= 0 && k == done_cyc + 1 && !cmd_if.cmd_ready) ready_ok = 1'b0;
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
        end
    endtask

    sweep_cmd_t  c;
    logic [63:0] trace;
    int          done_cyc;
    int          done_cnt;
    bit          en_seen;
    bit          overlap;
    bit          dir_at2;
    bit          ready_ok;
    int          k_hit;

    initial begin
        rst                 = 1'b1;
        abort               = 1'b0;
        cmd_if.cmd_valid    = 1'b0;
        cmd_if.cmd_start    = '0;
        cmd_if.cmd_end      = '0;
        cmd_if.cmd_reps     = '0;
        cmd_if.cmd_pingpong = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("rst_outs", {56'd0, ctr_enable, ctr_up_down, ctr_load, busy, done, 3'd0}, 64'd0);
        check("rst_data_in", {60'd0, ctr_data_in}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Up sweep 2 -> 6
        c = '{start_val: 4'd2, end_val: 4'd6, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b0);
        run_sweep(c.start_val, trace, done_cyc, done_cnt, en_seen, overlap, dir_at2, ready_ok);
        check("up_trace", trace, 64'h23456);
        check("up_done_cyc", done_cyc, 64'd7);
        check("up_done_cnt", done_cnt, 64'd1);
        check("up_dir", {63'd0, dir_at2}, 64'd0);
        check("up_overlap", {63'd0, overlap}, 64'd0);
        check("up_ready", {63'd0, ready_ok}, 64'd1);
        check("up_hold", {60'd0, ctr_count}, 64'd6);
        check("up_idle_busy", {63'd0, busy}, 64'd0);

        // Down sweep 9 -> 3
        c = '{start_val: 4'd9, end_val: 4'd3, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b0);
        run_sweep(c.start_val, trace, done_cyc, done_cnt, en_seen, overlap, dir_at2, ready_ok);
        check("dn_trace", trace, 64'h9876543);
        check("dn_done_cyc", done_cyc, 64'd9);
        check("dn_dir", {63'd0, dir_at2}, 64'd1);
        check("dn_ready", {63'd0, ready_ok}, 64'd1);
        check("dn_hold", {60'd0, ctr_count}, 64'd3);

        // Zero-length sweep, issued together with an abort that IDLE must ignore
        c = '{start_val: 4'd5, end_val: 4'd5, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b1);
        run_sweep(c.start_val, trace, done_cyc, done_cnt, en_seen, overlap, dir_at2, ready_ok);
        check("eq_done_cyc", done_cyc, 64'd3);
        check("eq_done_cnt", done_cnt, 64'd1);
        check("eq_no_enable", {63'd0, en_seen}, 64'd0);
        check("eq_hold", {60'd0, ctr_count}, 64'd5);

        // Repeats 1 -> 3, reps=2, pingpong requested
        c = '{start_val: 4'd1, end_val: 4'd3, reps: 4'd2, pingpong: 1'b1};
        send_cmd(c, 1'b0);
        run_sweep(c.start_val, trace, done_cyc, done_cnt, en_seen, overlap, dir_at2, ready_ok);
`ifdef COUNTER_SWEEP_PINGPONG_EN
        check("rep_trace", trace, 64'h1232123);
        check("rep_done_cyc", done_cyc, 64'd11);
`else
        check("rep_trace", trace, 64'h123123123);
        check("rep_done_cyc", done_cyc, 64'd13);
`endif
        check("rep_done_cnt", done_cnt, 64'd1);
        check("rep_overlap", {63'd0, overlap}, 64'd0);
        check("rep_ready", {63'd0, ready_ok}, 64'd1);

        // Abort at count 4 on a 0 -> 10 sweep
        c = '{start_val: 4'd0, end_val: 4'd10, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b0);
        k_hit = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k >= 2 && ctr_count == 4'd4) begin
                k_hit = k;
                break;
            end
        end
        check("ab_reach4", k_hit, 64'd6);
        check("ab_en_before", {63'd0, ctr_enable}, 64'd1);
        abort = 1'b1;
        #1;
        check("ab_en_gated", {62'd0, ctr_enable, ctr_load}, 64'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        check("ab_ready_next", {62'd0, cmd_if.cmd_ready, busy}, 64'd2);
        if (done) done_cnt++;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("ab_count_held", {60'd0, ctr_count}, 64'd4);
        check("ab_no_done", done_cnt, 64'd0);

        // Reset mid-RUN, then a fresh command 3 -> 4
        c = '{start_val: 4'd0, end_val: 4'd10, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b0);
        repeat (4) @(negedge clk);
        check("rr_running", {63'd0, ctr_enable}, 64'd1);
        rst = 1'b1;
        #1;
        check("rr_outs", {59'd0, ctr_enable, ctr_up_down, ctr_load, busy, done}, 64'd0);
        check("rr_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("rr_count", {60'd0, ctr_count}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        c = '{start_val: 4'd3, end_val: 4'd4, reps: 4'd0, pingpong: 1'b0};
        send_cmd(c, 1'b0);
        run_sweep(c.start_val, trace, done_cyc, done_cnt, en_seen, overlap, dir_at2, ready_ok);
        check("rr_trace", trace, 64'h34);
        check("rr_done_cyc", done_cyc, 64'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
